count_stream_decoder: RTL and testbench

Receiving end of the up/down counter interface: samples a WIDTH-bit count stream and decodes the counting direction, wrap-around events, direction reversals and illegal jumps. Sits downstream of up_down_counter (or any modulo-2^WIDTH counter) as an on-chip monitor, giving status flags to control logic and to the verification bench. Contains a small tracking FSM with a consecutive-error counter.

---
 rtl/count_pkg.sv | 23 ++
 rtl/count_step_classify.sv | 31 +++
 rtl/count_stream_decoder.sv | 119 +++++++++++
 tb/tb_count_stream_decoder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared types for the count-stream decoder: FSM state encoding, step classes
// and the default counter range.
package count_pkg;

  localparam int COUNT_WIDTH = 3;
  localparam int MAX_COUNT   = (1 << COUNT_WIDTH) - 1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_ACQUIRE    = 3'd1;
  localparam state_t ST_TRACK_UP   = 3'd2;
  localparam state_t ST_TRACK_DOWN = 3'd3;
  localparam state_t ST_FAULT      = 3'd4;

  typedef enum logic [1:0] {
    STEP_UP,
    STEP_DOWN,
    STEP_HOLD,
    STEP_ILLEGAL
  } step_t;

endpackage

// File: rtl/count_step_classify.sv
// Combinational step classifier: modular difference between two successive
// counter samples, plus detection of a legal step across the max<->0 boundary.
module count_step_classify
  import count_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
  output step_t            step,
  output logic             wrap
);

  logic [WIDTH-1:0] delta;

  always_comb begin
    delta = cur - prev;
    step  = STEP_ILLEGAL;
    wrap  = 1'b0;
    if (delta == WIDTH'(1)) begin
      step = STEP_UP;
      wrap = (prev == {WIDTH{1'b1}});
    end else if (delta == {WIDTH{1'b1}}) begin
      step = STEP_DOWN;
      wrap = (prev == {WIDTH{1'b0}});
    end else if (delta == {WIDTH{1'b0}}) begin
      step = STEP_HOLD;
    end
  end

endmodule

// File: rtl/count_stream_decoder.sv
// Monitors a modulo-2^WIDTH count stream: locks onto its direction, flags
// wraps, reversals and illegal jumps, and faults after repeated bad steps.
module count_stream_decoder
  import count_pkg::*;
#(
  parameter int WIDTH     = COUNT_WIDTH,
  parameter int ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clear,
  output logic             dir_up,
  output logic             locked,
  output logic             wrap_pulse,
  output logic             reverse_pulse,
  output logic             err_pulse,
  output logic             fault,
  output logic [WIDTH-1:0] prev_count
);

  localparam logic [3:0] ERR_LIM = 4'(ERR_LIMIT);

  state_t           state, state_nxt;
  logic [3:0]       err_cnt, err_nxt, err_inc;
  logic             dir_nxt, wrap_nxt, rev_nxt, errp_nxt;
  logic [WIDTH-1:0] prev_nxt;
  step_t            step;
  logic             step_wrap;

  count_step_classify #(.WIDTH(WIDTH)) u_classify (
    .prev (prev_count),
    .cur  (count_in),
    .step (step),
    .wrap (step_wrap)
  );

  assign err_inc = err_cnt + 4'd1;

  always_comb begin
    state_nxt = state;
    err_nxt   = err_cnt;
    dir_nxt   = dir_up;
    prev_nxt  = prev_count;
    wrap_nxt  = 1'b0;
    rev_nxt   = 1'b0;
    errp_nxt  = 1'b0;
    if (clear) begin
      state_nxt = ST_IDLE;
      err_nxt   = 4'd0;
    end else if (sample_en && state != ST_FAULT) begin
      prev_nxt = count_in;
      case (state)
        ST_IDLE: state_nxt = ST_ACQUIRE;
        ST_ACQUIRE: begin
          // err_cnt only counts while tracking; acquisition errors just pulse
          case (step)
            STEP_UP:      begin state_nxt = ST_TRACK_UP;   dir_nxt = 1'b1; wrap_nxt = step_wrap; end
            STEP_DOWN:    begin state_nxt = ST_TRACK_DOWN; dir_nxt = 1'b0; wrap_nxt = step_wrap; end
            STEP_ILLEGAL: errp_nxt = 1'b1;
            default:      ;
          endcase
        end
        ST_TRACK_UP, ST_TRACK_DOWN: begin
          case (step)
            STEP_UP: begin
              err_nxt   = 4'd0;
              wrap_nxt  = step_wrap;
              rev_nxt   = (state == ST_TRACK_DOWN);
              state_nxt = ST_TRACK_UP;
              dir_nxt   = 1'b1;
            end
            STEP_DOWN: begin
              err_nxt   = 4'd0;
              wrap_nxt  = step_wrap;
              rev_nxt   = (state == ST_TRACK_UP);
              state_nxt = ST_TRACK_DOWN;
              dir_nxt   = 1'b0;
            end
            STEP_ILLEGAL: begin
              errp_nxt = 1'b1;
              err_nxt  = err_inc;
              if (err_inc == ERR_LIM) state_nxt = ST_FAULT;
            end
            default: ;
          endcase
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Registered outputs: flags describe the sample seen on the previous edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      err_cnt       <= 4'd0;
      dir_up        <= 1'b0;
      locked        <= 1'b0;
      wrap_pulse    <= 1'b0;
      reverse_pulse <= 1'b0;
      err_pulse     <= 1'b0;
      fault         <= 1'b0;
      prev_count    <= '0;
    end else begin
      state         <= state_nxt;
      err_cnt       <= err_nxt;
      dir_up        <= dir_nxt;
      locked        <= (state_nxt == ST_TRACK_UP) || (state_nxt == ST_TRACK_DOWN);
      wrap_pulse    <= wrap_nxt;
      reverse_pulse <= rev_nxt;
      err_pulse     <= errp_nxt;
      fault         <= (state_nxt == ST_FAULT);
      prev_count    <= prev_nxt;
    end
  end

endmodule

// File: tb/tb_count_stream_decoder.sv
// Directed bench for count_stream_decoder (WIDTH=3, ERR_LIMIT=3); each step
// checks {locked, dir_up, wrap, reverse, err, fault, prev_count[2:0]}.
module tb_count_stream_decoder;

  logic       clk = 1'b0;
  logic       reset, sample_en, clear;
  logic [2:0] count_in;
  logic       dir_up, locked, wrap_pulse, reverse_pulse, err_pulse, fault;
  logic [2:0] prev_count;
  int         total = 0;
  int         bad   = 0;

  count_stream_decoder #(.WIDTH(3), .ERR_LIMIT(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_en     (sample_en),
    .count_in      (count_in),
    .clear         (clear),
    .dir_up        (dir_up),
    .locked        (locked),
    .wrap_pulse    (wrap_pulse),
    .reverse_pulse (reverse_pulse),
    .err_pulse     (err_pulse),
    .fault         (fault),
    .prev_count    (prev_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b (L D W R E F prev)", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then check the registered result after the edge.
  task automatic step(input string tag, input logic rst, input logic en,
                      input logic clr, input logic [2:0] c, input logic [8:0] exp);
    reset     = rst;
    sample_en = en;
    clear     = clr;
    count_in  = c;
    @(posedge clk);
    #1;
    chk(tag, {locked, dir_up, wrap_pulse, reverse_pulse, err_pulse, fault, prev_count}, exp);
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; clear = 1'b0; count_in = 3'd0;
    @(posedge clk); #1;
    step("reset",     1, 0, 0, 3'd5, 9'b0_0_0_0_0_0_000);

    // 1: count up through a wrap
    step("t1_s0",     0, 1, 0, 3'd0, 9'b0_0_0_0_0_0_000);
    step("t1_lock",   0, 1, 0, 3'd1, 9'b1_1_0_0_0_0_001);
    for (int i = 2; i < 8; i++)
      step("t1_up",   0, 1, 0, 3'(i), {6'b1_1_0_0_0_0, 3'(i)});
    step("t1_wrap",   0, 1, 0, 3'd0, 9'b1_1_1_0_0_0_000);
    step("t1_s1",     0, 1, 0, 3'd1, 9'b1_1_0_0_0_0_001);

    // 2: up to 5, reverse down through a wrap
    for (int i = 2; i < 6; i++)
      step("t2_up",   0, 1, 0, 3'(i), {6'b1_1_0_0_0_0, 3'(i)});
    step("t2_rev",    0, 1, 0, 3'd4, 9'b1_0_0_1_0_0_100);
    for (int i = 3; i >= 0; i--)
      step("t2_down", 0, 1, 0, 3'(i), {6'b1_0_0_0_0_0, 3'(i)});
    step("t2_wrap",   0, 1, 0, 3'd7, 9'b1_0_1_0_0_0_111);

    // 3: reverse+wrap together, then three illegal steps to FAULT
    step("t3_revwr",  0, 1, 0, 3'd0, 9'b1_1_1_1_0_0_000);
    step("t3_up1",    0, 1, 0, 3'd1, 9'b1_1_0_0_0_0_001);
    step("t3_up2",    0, 1, 0, 3'd2, 9'b1_1_0_0_0_0_010);
    step("t3_ill1",   0, 1, 0, 3'd5, 9'b1_1_0_0_1_0_101);
    step("t3_ill2",   0, 1, 0, 3'd1, 9'b1_1_0_0_1_0_001);
    step("t3_fault",  0, 1, 0, 3'd6, 9'b0_1_0_0_1_1_110);
    step("t3_frz1",   0, 1, 0, 3'd7, 9'b0_1_0_0_0_1_110);
    step("t3_frz2",   0, 1, 0, 3'd0, 9'b0_1_0_0_0_1_110);

    // 4: clear beats sample_en, then reacquire
    step("t4_clear",  0, 1, 1, 3'd4, 9'b0_1_0_0_0_0_110);
    step("t4_acq",    0, 1, 0, 3'd2, 9'b0_1_0_0_0_0_010);
    step("t4_lock",   0, 1, 0, 3'd3, 9'b1_1_0_0_0_0_011);

    // 5: legal step resets err_cnt; hold and gaps preserve it
    step("t5_ill1",   0, 1, 0, 3'd6, 9'b1_1_0_0_1_0_110);
    step("t5_ill2",   0, 1, 0, 3'd0, 9'b1_1_0_0_1_0_000);
    step("t5_legal",  0, 1, 0, 3'd1, 9'b1_1_0_0_0_0_001);
    step("t5_ill3",   0, 1, 0, 3'd4, 9'b1_1_0_0_1_0_100);
    step("t5_ill4",   0, 1, 0, 3'd7, 9'b1_1_0_0_1_0_111);
    step("t5_wrap",   0, 1, 0, 3'd0, 9'b1_1_1_0_0_0_000);
    for (int i = 0; i < 3; i++)
      step("t5_hold", 0, 1, 0, 3'd0, 9'b1_1_0_0_0_0_000);
    step("t5_gap",    0, 0, 0, 3'd5, 9'b1_1_0_0_0_0_000);
    step("t5_up",     0, 1, 0, 3'd1, 9'b1_1_0_0_0_0_001);
    step("t5_ill5",   0, 1, 0, 3'd5, 9'b1_1_0_0_1_0_101);
    step("t5_hold2",  0, 1, 0, 3'd5, 9'b1_1_0_0_0_0_101);
    step("t5_gap2",   0, 0, 0, 3'd2, 9'b1_1_0_0_0_0_101);
    step("t5_ill6",   0, 1, 0, 3'd1, 9'b1_1_0_0_1_0_001);
    step("t5_fault",  0, 1, 0, 3'd6, 9'b0_1_0_0_1_1_110);
    step("t5_clear",  0, 0, 1, 3'd6, 9'b0_1_0_0_0_0_110);

    // 6: lock down, then reset mid-track with sample_en high
    step("t6_acq",    0, 1, 0, 3'd5, 9'b0_1_0_0_0_0_101);
    step("t6_lockdn", 0, 1, 0, 3'd4, 9'b1_0_0_0_0_0_100);
    step("t6_down",   0, 1, 0, 3'd3, 9'b1_0_0_0_0_0_011);
    step("t6_reset",  1, 1, 0, 3'd2, 9'b0_0_0_0_0_0_000);
    step("t6_idle",   0, 1, 0, 3'd1, 9'b0_0_0_0_0_0_001);

    // Illegal steps in ACQUIRE pulse but never fault; lock via a down wrap
    step("acq_ill1",  0, 1, 0, 3'd5, 9'b0_0_0_0_1_0_101);
    step("acq_ill2",  0, 1, 0, 3'd2, 9'b0_0_0_0_1_0_010);
    step("acq_ill3",  0, 1, 0, 3'd7, 9'b0_0_0_0_1_0_111);
    step("acq_ill4",  0, 1, 0, 3'd1, 9'b0_0_0_0_1_0_001);
    step("acq_wrap",  0, 1, 0, 3'd0, 9'b1_0_0_0_0_0_000);
    step("acq_dwrap", 0, 1, 0, 3'd7, 9'b1_0_1_0_0_0_111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
